// File: rtl/vfpu_dutw_rsp_if.sv
// Bundles the operation input, execution-unit handshake and result/status signals
// of vfpu_dutw_rsp. The slave modport is the DUT view; the master modport is the driving side.
interface vfpu_dutw_rsp_if;
   logic        op_vld;
   logic [5:0]  vfpu_ins;
   logic [31:0] operand_a;
   logic [31:0] operand_b;
   logic [31:0] operand_c;
   logic        op_rdy;
   logic        flush;
   logic        exe_vld;
   logic [5:0]  exe_ins;
   logic [31:0] exe_a;
   logic [31:0] exe_b;
   logic [31:0] exe_c;
   logic        exe_rdy;
   logic        exe_res_vld;
   logic [31:0] exe_res;
   logic [31:0] res;
   logic        res_rdy;
   logic        busy;
   logic        err_ovf;
   logic        err_unexp;

   modport slave (
      input  op_vld, vfpu_ins, operand_a, operand_b, operand_c, flush,
             exe_rdy, exe_res_vld, exe_res,
      output op_rdy, exe_vld, exe_ins, exe_a, exe_b, exe_c,
             res, res_rdy, busy, err_ovf, err_unexp
   );

   modport master (
      output op_vld, vfpu_ins, operand_a, operand_b, operand_c, flush,
             exe_rdy, exe_res_vld, exe_res,
      input  op_rdy, exe_vld, exe_ins, exe_a, exe_b, exe_c,
             res, res_rdy, busy, err_ovf, err_unexp
   );
endinterface

// File: rtl/vfpu_dutw_rsp.sv
// Operation queue in front of a vector FPU execution unit: credit-limited issue,
// in-order result return, flush with drain of in-flight work, sticky error flags.
module vfpu_dutw_rsp #(
   parameter int FIFO_DEPTH = 4,
   parameter int MAX_OUT    = 4
) (
   input logic            clk,
   input logic            rst,
   vfpu_dutw_rsp_if.slave bus
);
   localparam int          PW       = $clog2(FIFO_DEPTH);
   localparam int          EW       = 6 + 3 * 32;
   localparam logic [PW:0] FULL_CNT = (PW + 1)'(FIFO_DEPTH);
   localparam logic [3:0]  OUT_MAX  = 4'(MAX_OUT);

   typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

   state_t        state_q, state_d;
   logic [EW-1:0] mem_q [FIFO_DEPTH];
   logic [EW-1:0] mem_d [FIFO_DEPTH];
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW:0]   count_q, count_d;
   logic [3:0]    out_q, out_d;
   logic          exe_vld_q, exe_vld_d;
   logic [EW-1:0] exe_data_q, exe_data_d;
   logic [31:0]   res_q, res_d;
   logic          res_rdy_q, res_rdy_d;
   logic          err_ovf_q, err_ovf_d;
   logic          err_unexp_q, err_unexp_d;

   logic          full, flush_act, op_rdy, push, pop, result_ok;
   logic [EW-1:0] push_data, head_d;

   assign full      = (count_q == FULL_CNT);
   assign flush_act = bus.flush && (state_q == ACTIVE);
   assign op_rdy    = !full && (state_q != DRAIN);
   assign push      = bus.op_vld && op_rdy && !flush_act;
   assign pop       = exe_vld_q && bus.exe_rdy;
   assign result_ok = bus.exe_res_vld && (out_q != '0);
   assign push_data = {bus.vfpu_ins, bus.operand_a, bus.operand_b, bus.operand_c};

   always_comb begin
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop) count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
      if (flush_act) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end
   end

   always_comb begin
      out_d = out_q;
      if (pop && !result_ok) out_d = out_q + 1'b1;
      else if (result_ok && !pop) out_d = out_q - 1'b1;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (push) state_d = ACTIVE;
         ACTIVE: begin
            if (flush_act) state_d = DRAIN;
            else if ((count_q == '0) && (out_q == '0) && !push) state_d = IDLE;
         end
         DRAIN:   if (out_d == '0) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // The offer register is loaded with next cycle's head so a push into an empty queue is visible one cycle later
   always_comb begin
      head_d      = (push && (rd_ptr_d == wr_ptr_q)) ? push_data : mem_q[rd_ptr_d];
      exe_vld_d   = (state_d == ACTIVE) && (count_d != '0) && (out_d < OUT_MAX);
      exe_data_d  = (count_d != '0) ? head_d : exe_data_q;
      res_d       = res_q;
      res_rdy_d   = 1'b0;
      if (result_ok && (state_q == ACTIVE)) begin
         res_d     = bus.exe_res;
         res_rdy_d = 1'b1;
      end
      err_ovf_d   = err_ovf_q | (bus.op_vld && full && !flush_act);
      err_unexp_d = err_unexp_q | (bus.exe_res_vld && (out_q == '0));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         count_q     <= '0;
         out_q       <= '0;
         exe_vld_q   <= 1'b0;
         exe_data_q  <= '0;
         res_q       <= '0;
         res_rdy_q   <= 1'b0;
         err_ovf_q   <= 1'b0;
         err_unexp_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         mem_q       <= mem_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         count_q     <= count_d;
         out_q       <= out_d;
         exe_vld_q   <= exe_vld_d;
         exe_data_q  <= exe_data_d;
         res_q       <= res_d;
         res_rdy_q   <= res_rdy_d;
         err_ovf_q   <= err_ovf_d;
         err_unexp_q <= err_unexp_d;
      end
   end

   assign bus.op_rdy    = op_rdy;
   assign bus.exe_vld   = exe_vld_q;
   assign bus.exe_ins   = exe_data_q[EW-1 -: 6];
   assign bus.exe_a     = exe_data_q[95:64];
   assign bus.exe_b     = exe_data_q[63:32];
   assign bus.exe_c     = exe_data_q[31:0];
   assign bus.res       = res_q;
   assign bus.res_rdy   = res_rdy_q;
   assign bus.busy      = (state_q != IDLE);
   assign bus.err_ovf   = err_ovf_q;
   assign bus.err_unexp = err_unexp_q;
endmodule

// File: tb/tb_vfpu_dutw_rsp.sv
// Directed bench for vfpu_dutw_rsp: a per-cycle vector table for single/back-to-back ops,
// then hand sequences for backpressure, credit limit, flush/drain, simultaneity and errors.
module tb_vfpu_dutw_rsp;
   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;
   int   issued;

   vfpu_dutw_rsp_if bus_if ();

   vfpu_dutw_rsp #(.FIFO_DEPTH(4), .MAX_OUT(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        op_vld;
      logic [5:0]  ins;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] c;
      logic        exe_rdy;
      logic        res_vld;
      logic [31:0] exe_res;
      logic        x_exe_vld;
      logic [5:0]  x_ins;
      logic [31:0] x_a;
      logic [31:0] x_c;
      logic        x_res_rdy;
      logic [31:0] x_res;
      logic        x_busy;
   } vec_t;

   vec_t vecs [10];

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic op_vld, input logic [5:0] ins, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] c, input logic exe_rdy,
                                input logic res_vld, input logic [31:0] exe_res, input logic flush);
      bus_if.op_vld      = op_vld;
      bus_if.vfpu_ins    = ins;
      bus_if.operand_a   = a;
      bus_if.operand_b   = b;
      bus_if.operand_c   = c;
      bus_if.exe_rdy     = exe_rdy;
      bus_if.exe_res_vld = res_vld;
      bus_if.exe_res     = exe_res;
      bus_if.flush       = flush;
   endtask

   task automatic doReset;
      applyStimulus(1'b0, 6'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
      rst = 1'b1;
      tick;
      tick;
      rst = 1'b0;
   endtask

   initial begin
      // Inputs per cycle, then expected outputs just after that cycle's closing edge
      vecs[0] = '{1'b1, 6'h01, 32'h3F800000, 32'h40000000, 32'h0, 1'b1, 1'b0, 32'h0,
                  1'b1, 6'h01, 32'h3F800000, 32'h0, 1'b0, 32'h0, 1'b1};
      vecs[1] = '{1'b0, 6'h00, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0,
                  1'b0, 6'h01, 32'h3F800000, 32'h0, 1'b0, 32'h0, 1'b1};
      vecs[2] = '{1'b0, 6'h00, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h40400000,
                  1'b0, 6'h01, 32'h3F800000, 32'h0, 1'b1, 32'h40400000, 1'b1};
      vecs[3] = '{1'b0, 6'h00, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0,
                  1'b0, 6'h01, 32'h3F800000, 32'h0, 1'b0, 32'h40400000, 1'b0};
      vecs[4] = '{1'b1, 6'h2A, 32'h11111111, 32'h22222222, 32'h33333333, 1'b0, 1'b0, 32'h0,
                  1'b1, 6'h2A, 32'h11111111, 32'h33333333, 1'b0, 32'h40400000, 1'b1};
      vecs[5] = '{1'b0, 6'h00, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0,
                  1'b1, 6'h2A, 32'h11111111, 32'h33333333, 1'b0, 32'h40400000, 1'b1};
      vecs[6] = '{1'b1, 6'h15, 32'hAAAA0000, 32'h0, 32'h0000000C, 1'b1, 1'b0, 32'h0,
                  1'b1, 6'h15, 32'hAAAA0000, 32'h0000000C, 1'b0, 32'h40400000, 1'b1};
      vecs[7] = '{1'b0, 6'h00, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h00000005,
                  1'b0, 6'h15, 32'hAAAA0000, 32'h0000000C, 1'b1, 32'h00000005, 1'b1};
      vecs[8] = '{1'b0, 6'h00, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h00000006,
                  1'b0, 6'h15, 32'hAAAA0000, 32'h0000000C, 1'b1, 32'h00000006, 1'b1};
      vecs[9] = '{1'b0, 6'h00, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0,
                  1'b0, 6'h15, 32'hAAAA0000, 32'h0000000C, 1'b0, 32'h00000006, 1'b0};

      doReset;
      checkOutput("rst_op_rdy", 32'(bus_if.op_rdy), 32'd1);
      checkOutput("rst_exe_vld", 32'(bus_if.exe_vld), 32'd0);
      checkOutput("rst_exe_ins", 32'(bus_if.exe_ins), 32'd0);
      checkOutput("rst_exe_a", bus_if.exe_a, 32'd0);
      checkOutput("rst_res_rdy", 32'(bus_if.res_rdy), 32'd0);
      checkOutput("rst_res", bus_if.res, 32'd0);
      checkOutput("rst_busy", 32'(bus_if.busy), 32'd0);
      checkOutput("rst_err_ovf", 32'(bus_if.err_ovf), 32'd0);
      checkOutput("rst_err_unexp", 32'(bus_if.err_unexp), 32'd0);

      for (int i = 0; i < 10; i++) begin
         applyStimulus(vecs[i].op_vld, vecs[i].ins, vecs[i].a, vecs[i].b, vecs[i].c,
                       vecs[i].exe_rdy, vecs[i].res_vld, vecs[i].exe_res, 1'b0);
         tick;
         checkOutput($sformatf("vec%0d_exe_vld", i), 32'(bus_if.exe_vld), 32'(vecs[i].x_exe_vld));
         checkOutput($sformatf("vec%0d_exe_ins", i), 32'(bus_if.exe_ins), 32'(vecs[i].x_ins));
         checkOutput($sformatf("vec%0d_exe_a", i), bus_if.exe_a, vecs[i].x_a);
         checkOutput($sformatf("vec%0d_exe_c", i), bus_if.exe_c, vecs[i].x_c);
         checkOutput($sformatf("vec%0d_res_rdy", i), 32'(bus_if.res_rdy), 32'(vecs[i].x_res_rdy));
         checkOutput($sformatf("vec%0d_res", i), bus_if.res, vecs[i].x_res);
         checkOutput($sformatf("vec%0d_busy", i), 32'(bus_if.busy), 32'(vecs[i].x_busy));
      end

      // Backpressure: four fill the queue, the fifth is dropped, then all four drain in order
      doReset;
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 6'(i + 1), 32'(i * 16), 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
         tick;
         checkOutput("bp_op_rdy", 32'(bus_if.op_rdy), (i < 3) ? 32'd1 : 32'd0);
         checkOutput("bp_err_ovf", 32'(bus_if.err_ovf), (i == 4) ? 32'd1 : 32'd0);
      end
      for (int k = 0; k < 4; k++) begin
         applyStimulus(1'b0, 6'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
         checkOutput("bp_exe_vld", 32'(bus_if.exe_vld), 32'd1);
         checkOutput("bp_order", 32'(bus_if.exe_ins), 32'(k + 1));
         checkOutput("bp_operand", bus_if.exe_a, 32'(k * 16));
         tick;
      end
      checkOutput("bp_dropped_not_issued", 32'(bus_if.exe_vld), 32'd0);
      checkOutput("bp_queue_empty", 32'(dut.count_q), 32'd0);

      // Credit limit: six ops, no results -> four issued, two held
      doReset;
      issued = 0;
      for (int cyc = 0; cyc < 12; cyc++) begin
         applyStimulus(cyc < 6, 6'(cyc + 1), 32'(cyc), 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
         tick;
         if (bus_if.exe_vld) begin
            issued++;
            checkOutput("credit_order", 32'(bus_if.exe_ins), 32'(issued));
         end
      end
      checkOutput("credit_issued", 32'(issued), 32'd4);
      checkOutput("credit_held", 32'(dut.count_q), 32'd2);
      applyStimulus(1'b0, 6'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h00000077, 1'b0);
      checkOutput("credit_no_issue_at_max", 32'(bus_if.exe_vld), 32'd0);
      tick;
      checkOutput("credit_reissue_vld", 32'(bus_if.exe_vld), 32'd1);
      checkOutput("credit_reissue_ins", 32'(bus_if.exe_ins), 32'd5);
      checkOutput("credit_res_rdy", 32'(bus_if.res_rdy), 32'd1);
      checkOutput("credit_res", bus_if.res, 32'h00000077);
      // Issue and result in the same cycle keep the outstanding count
      applyStimulus(1'b0, 6'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 32'h00000078, 1'b0);
      tick;
      checkOutput("simul_out_kept", 32'(dut.out_q), 32'd3);
      checkOutput("simul_next_vld", 32'(bus_if.exe_vld), 32'd1);
      checkOutput("simul_next_ins", 32'(bus_if.exe_ins), 32'd6);
      applyStimulus(1'b0, 6'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
      tick;
      checkOutput("credit_relimit", 32'(bus_if.exe_vld), 32'd0);
      checkOutput("credit_out_max", 32'(dut.out_q), 32'd4);

      // Queue at 3 with push+pop stays at 3; push+pop while full drops the push
      doReset;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 6'(i + 1), 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
         tick;
      end
      checkOutput("q3_count", 32'(dut.count_q), 32'd3);
      applyStimulus(1'b1, 6'h04, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
      tick;
      checkOutput("q3_pushpop_count", 32'(dut.count_q), 32'd3);
      checkOutput("q3_pushpop_head", 32'(bus_if.exe_ins), 32'd2);
      applyStimulus(1'b1, 6'h05, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
      tick;
      checkOutput("q4_count", 32'(dut.count_q), 32'd4);
      checkOutput("q4_op_rdy", 32'(bus_if.op_rdy), 32'd0);
      applyStimulus(1'b1, 6'h3F, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
      tick;
      checkOutput("full_pushpop_count", 32'(dut.count_q), 32'd3);
      checkOutput("full_pushpop_ovf", 32'(bus_if.err_ovf), 32'd1);
      checkOutput("full_pushpop_head", 32'(bus_if.exe_ins), 32'd3);

      // Flush with 3 outstanding and 2 queued, then drain
      doReset;
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 6'(i + 1), 32'h0, 32'h0, 32'h0, i < 4, 1'b0, 32'h0, 1'b0);
         tick;
      end
      checkOutput("fl_pre_count", 32'(dut.count_q), 32'd2);
      checkOutput("fl_pre_out", 32'(dut.out_q), 32'd3);
      applyStimulus(1'b1, 6'h30, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
      tick;
      checkOutput("fl_count", 32'(dut.count_q), 32'd0);
      checkOutput("fl_exe_vld", 32'(bus_if.exe_vld), 32'd0);
      checkOutput("fl_op_rdy", 32'(bus_if.op_rdy), 32'd0);
      checkOutput("fl_busy", 32'(bus_if.busy), 32'd1);
      checkOutput("fl_no_ovf", 32'(bus_if.err_ovf), 32'd0);
      for (int r = 0; r < 3; r++) begin
         applyStimulus(1'b0, 6'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1, 32'(256 + r), 1'b0);
         tick;
         checkOutput("drain_res_rdy", 32'(bus_if.res_rdy), 32'd0);
         checkOutput("drain_exe_vld", 32'(bus_if.exe_vld), 32'd0);
         checkOutput("drain_busy", 32'(bus_if.busy), (r < 2) ? 32'd1 : 32'd0);
         checkOutput("drain_op_rdy", 32'(bus_if.op_rdy), (r < 2) ? 32'd0 : 32'd1);
      end
      checkOutput("drain_err_unexp", 32'(bus_if.err_unexp), 32'd0);
      applyStimulus(1'b1, 6'h21, 32'hCAFE0001, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
      tick;
      checkOutput("idle_flush_vld", 32'(bus_if.exe_vld), 32'd1);
      checkOutput("idle_flush_ins", 32'(bus_if.exe_ins), 32'h21);
      checkOutput("idle_flush_a", bus_if.exe_a, 32'hCAFE0001);

      // Unexpected result after reset, and after abandoning in-flight work
      doReset;
      applyStimulus(1'b0, 6'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h0000DEAD, 1'b0);
      tick;
      checkOutput("unexp_flag", 32'(bus_if.err_unexp), 32'd1);
      checkOutput("unexp_res_rdy", 32'(bus_if.res_rdy), 32'd0);
      checkOutput("unexp_res", bus_if.res, 32'd0);
      doReset;
      checkOutput("unexp_cleared", 32'(bus_if.err_unexp), 32'd0);
      applyStimulus(1'b1, 6'h07, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
      tick;
      applyStimulus(1'b0, 6'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
      tick;
      checkOutput("midop_out", 32'(dut.out_q), 32'd1);
      doReset;
      checkOutput("midop_rst_busy", 32'(bus_if.busy), 32'd0);
      applyStimulus(1'b0, 6'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 32'h00000099, 1'b0);
      tick;
      checkOutput("midop_late_unexp", 32'(bus_if.err_unexp), 32'd1);
      checkOutput("midop_late_res_rdy", 32'(bus_if.res_rdy), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
